// File: rtl/enc_defines.sv
// Shared definitions for the motion-vector-difference Exp-Golomb decoder:
// field widths, prefix limit, FSM encoding and the codeNum prefix helper.
package enc_defines;

    localparam int FMVD_LEN   = 11;  // signed quarter-pel mvd width
    localparam int SE_LEN     = 5;   // width of one element length (max 21)
    localparam int MAX_PREFIX = 10;  // longest legal zero prefix
    localparam int LEN_W      = 6;   // width of the pair length (max 42)
    localparam int ZCNT_W     = 4;   // zero / suffix counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_SUFFIX = 2'd2,
        ST_OUT    = 2'd3
    } mvd_state_e;

    // Offset contributed by an L-bit zero prefix: 2^L - 1.
    function automatic logic [FMVD_LEN-1:0] prefix_base(input logic [ZCNT_W-1:0] l);
        return (FMVD_LEN'(1) << l) - FMVD_LEN'(1);
    endfunction

endpackage

// File: rtl/ime_se_map.sv
// Combinational se(v) mapping: odd codeNum k -> +(k+1)/2, even k -> -(k/2).
module ime_se_map
    import enc_defines::*;
(
    input  logic        [FMVD_LEN-1:0] code_num,
    output logic signed [FMVD_LEN-1:0] se_val
);

    logic [FMVD_LEN-1:0] half;

    assign half = {1'b0, code_num[FMVD_LEN-1:1]};

    // Odd codes are positive (floor(k/2)+1), even codes negative (-(k/2)); 0 stays 0.
    always_comb begin
        if (code_num[0]) begin
            se_val = $signed(half + FMVD_LEN'(1));
        end else begin
            se_val = $signed(-half);
        end
    end

endmodule

// File: rtl/ime_mvd_expg_dec.sv
// Decodes an (x, y) pair of signed Exp-Golomb se(v) codes from a serial,
// MSB-first bitstream into quarter-pel motion vector differences.
//
// Handshakes: a bit moves when bit_valid_i && bit_ready_o at a rising clk
// edge; a pair moves when out_valid_o && out_ready_i at a rising clk edge.
// While out_valid_o is high its data is held and bit_ready_o stays low.
module ime_mvd_expg_dec
    import enc_defines::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr_i,
    input  logic                       bit_i,
    input  logic                       bit_valid_i,
    output logic                       bit_ready_o,
    output logic signed [FMVD_LEN-1:0] mvd_x_o,
    output logic signed [FMVD_LEN-1:0] mvd_y_o,
    output logic        [LEN_W-1:0]    len_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       err_o,
    output mvd_state_e                 dbg_state
);

    mvd_state_e                 state;
    logic        [ZCNT_W-1:0]   zcnt;      // prefix length L of current element
    logic        [ZCNT_W-1:0]   scnt;      // suffix bits still to collect
    logic        [MAX_PREFIX-1:0] suffix;
    logic                       is_y;      // current element is the y component
    logic signed [FMVD_LEN-1:0] x_hold;
    logic        [SE_LEN-1:0]   len_x;

    logic                       bit_acc;
    logic                       in_prefix;
    logic        [MAX_PREFIX-1:0] suffix_nxt;
    logic        [FMVD_LEN-1:0] code_num;
    logic signed [FMVD_LEN-1:0] se_val;
    logic        [SE_LEN-1:0]   elem_len;
    logic                       elem_done;

    assign dbg_state  = state;
    assign bit_acc    = bit_valid_i & bit_ready_o;
    assign in_prefix  = (state == ST_IDLE) || (state == ST_PREFIX);
    assign suffix_nxt = {suffix[MAX_PREFIX-2:0], bit_i};
    assign elem_len   = {zcnt, 1'b1};

    // codeNum of the element finishing this cycle; a lone '1' prefix gives 0.
    assign code_num = (state == ST_SUFFIX) ? prefix_base(zcnt) + {1'b0, suffix_nxt}
                                           : '0;

    // Element completes on a '1' with empty prefix or on the last suffix bit.
    assign elem_done = bit_acc &&
                       ((in_prefix && bit_i && (zcnt == '0)) ||
                        ((state == ST_SUFFIX) && (scnt == ZCNT_W'(1))));

    ime_se_map u_se_map (
        .code_num (code_num),
        .se_val   (se_val)
    );

    // Decode FSM with registered outputs; clr_i overrides every state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            zcnt        <= '0;
            scnt        <= '0;
            suffix      <= '0;
            is_y        <= 1'b0;
            x_hold      <= '0;
            len_x       <= '0;
            mvd_x_o     <= '0;
            mvd_y_o     <= '0;
            len_o       <= '0;
            out_valid_o <= 1'b0;
            err_o       <= 1'b0;
            bit_ready_o <= 1'b0;
        end else begin
            err_o       <= 1'b0;
            bit_ready_o <= 1'b1;
            if (clr_i) begin
                state       <= ST_IDLE;
                zcnt        <= '0;
                scnt        <= '0;
                suffix      <= '0;
                is_y        <= 1'b0;
                out_valid_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_PREFIX: begin
                        if (bit_acc && !bit_i) begin
                            if (zcnt == ZCNT_W'(MAX_PREFIX)) begin
                                // Prefix too long: drop the whole pair.
                                err_o <= 1'b1;
                                state <= ST_IDLE;
                                zcnt  <= '0;
                                is_y  <= 1'b0;
                            end else begin
                                zcnt  <= zcnt + ZCNT_W'(1);
                                state <= ST_PREFIX;
                            end
                        end else if (bit_acc && (zcnt != '0)) begin
                            state  <= ST_SUFFIX;
                            scnt   <= zcnt;
                            suffix <= '0;
                        end
                    end
                    ST_SUFFIX: begin
                        if (bit_acc) begin
                            suffix <= suffix_nxt;
                            scnt   <= scnt - ZCNT_W'(1);
                        end
                    end
                    ST_OUT: begin
                        if (out_ready_i) begin
                            out_valid_o <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            bit_ready_o <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase

                if (elem_done) begin
                    zcnt <= '0;
                    if (!is_y) begin
                        x_hold <= se_val;
                        len_x  <= elem_len;
                        is_y   <= 1'b1;
                        state  <= ST_PREFIX;
                    end else begin
                        mvd_x_o     <= x_hold;
                        mvd_y_o     <= se_val;
                        len_o       <= {1'b0, len_x} + {1'b0, elem_len};
                        out_valid_o <= 1'b1;
                        bit_ready_o <= 1'b0;
                        is_y        <= 1'b0;
                        state       <= ST_OUT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ime_mvd_expg_dec.sv
// Bench for the mvd Exp-Golomb pair decoder: fixed vectors, hand-built
// corner sequences and random pairs encoded by a value-level model.
module tb_ime_mvd_expg_dec;
    import enc_defines::*;

    localparam int W = 28;  // {x[10:0], y[10:0], len[5:0]}

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rstn, clr_i, bit_i, bit_valid_i, bit_ready_o;
    logic out_valid_o, out_ready_i, err_o;
    logic signed [10:0] mvd_x_o, mvd_y_o;
    logic [5:0] len_o;
    mvd_state_e dbg_state;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;
    int ready_mode = 1;  // 0: out_ready low, 1: high, 2: random

    logic bit_q[$];
    logic [W-1:0] exp_q[$];

    ime_mvd_expg_dec dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (clr_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .mvd_x_o     (mvd_x_o),
        .mvd_y_o     (mvd_y_o),
        .len_o       (len_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_o       (err_o),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model: value -> bits ----------------
    task automatic push_se(input int v, output int n);
        int k, m, l;
        k = (v > 0) ? 2 * v - 1 : -2 * v;
        m = k + 1;
        l = 0;
        while ((m >> (l + 1)) != 0) l++;
        for (int i = 0; i < l; i++) bit_q.push_back(1'b0);
        for (int i = l; i >= 0; i--) bit_q.push_back(1'((m >> i) & 1));
        n = 2 * l + 1;
    endtask

    task automatic push_pair(input int x, input int y);
        int nx, ny;
        logic [31:0] xv, yv, lv;
        push_se(x, nx);
        push_se(y, ny);
        xv = x; yv = y; lv = nx + ny;
        exp_q.push_back({xv[10:0], yv[10:0], lv[5:0]});
    endtask

    task automatic push_bits(input logic [41:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) bit_q.push_back(b[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic b);
        @(negedge clk);
        bit_valid_i = v;
        bit_i       = b;
        case (ready_mode)
            0:       out_ready_i = 1'b0;
            1:       out_ready_i = 1'b1;
            default: out_ready_i = 1'($urandom_range(1));
        endcase
    endtask

    task automatic drive_bits(input int pct, input int keep);
        int cyc = 0;
        while (bit_q.size() > keep && cyc < 20000) begin
            step($urandom_range(99) < pct, bit_q[0]);
            if (bit_valid_i && bit_ready_o) void'(bit_q.pop_front());
            cyc++;
        end
        check("drive_done", 32'(bit_q.size() <= keep), 32'd1);
        step(1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int limit);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < limit) begin
            step(1'b0, 1'b0);
            cyc++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic         stalled = 1'b0;
    logic [W-1:0] held;

    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            if (err_o) err_cnt++;
            if (stalled) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_pair", 32'({mvd_x_o, mvd_y_o, len_o}), 32'(held));
            end
            if (out_valid_o) begin
                check("ready_low_in_out", 32'(bit_ready_o), 32'd0);
                if (out_ready_i) begin
                    check("pair_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0)
                        check("pair", 32'({mvd_x_o, mvd_y_o, len_o}), 32'(exp_q.pop_front()));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {mvd_x_o, mvd_y_o, len_o};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [41:0] bits;
        int          nbits;
        logic [10:0] x;
        logic [10:0] y;
        logic [5:0]  len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int err_before;

        vecs[0] = '{bits: 42'b11,                       nbits: 2,  x: 11'd0,     y: 11'd0,     len: 6'd2};
        vecs[1] = '{bits: 42'b010_011,                  nbits: 6,  x: 11'd1,     y: 11'h7FF,   len: 6'd6};
        vecs[2] = '{bits: 42'b00100_0001000,            nbits: 12, x: 11'd2,     y: 11'd4,     len: 6'd12};
        vecs[3] = '{bits: 42'b0000000000_1_1111111111_1, nbits: 22, x: 11'h401,  y: 11'd0,     len: 6'd22};
        vecs[4] = '{bits: 42'b1_0000000000_1_0000000000, nbits: 22, x: 11'd0,    y: 11'd512,   len: 6'd22};
        vecs[5] = '{bits: 42'b011_1,                    nbits: 4,  x: 11'h7FF,   y: 11'd0,     len: 6'd4};

        // reset state
        rstn = 1'b0; clr_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bit_ready", 32'(bit_ready_o), 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_len", 32'(len_o), 32'd0);
        check("rst_mvd_x", 32'(mvd_x_o), 32'd0);
        check("rst_mvd_y", 32'(mvd_y_o), 32'd0);
        rstn = 1'b1;
        step(1'b0, 1'b0);
        check("ready_after_rst", 32'(bit_ready_o), 32'd1);

        // bits 1,1: one-cycle latency and ready returning after the handshake
        exp_q.push_back({11'd0, 11'd0, 6'd2});
        step(1'b1, 1'b1);
        check("lat_pre1", 32'(out_valid_o), 32'd0);
        step(1'b1, 1'b1);
        check("lat_pre2", 32'(out_valid_o), 32'd0);
        step(1'b0, 1'b0);
        check("lat_valid", 32'(out_valid_o), 32'd1);
        check("lat_len", 32'(len_o), 32'd2);
        check("lat_ready_same", 32'(bit_ready_o), 32'd0);
        step(1'b0, 1'b0);
        check("lat_done", 32'(out_valid_o), 32'd0);
        check("lat_ready_next", 32'(bit_ready_o), 32'd1);

        // table-driven vectors
        for (int i = 0; i < 6; i++) begin
            push_bits(vecs[i].bits, vecs[i].nbits);
            exp_q.push_back({vecs[i].x, vecs[i].y, vecs[i].len});
            drive_bits((i % 2 == 0) ? 100 : 60, 0);
            wait_drain(50);
        end

        // eleven zeros: error pulse, pair dropped, then 1,1 decodes (0,0)
        err_before = err_cnt;
        push_bits(42'b00000000000_11, 13);
        exp_q.push_back({11'd0, 11'd0, 6'd2});
        drive_bits(100, 0);
        wait_drain(50);
        check("err_pulses", 32'(err_cnt - err_before), 32'd1);

        // backpressure: output held, no bits taken, nothing lost
        begin
            int keep, cyc;
            ready_mode = 0;
            push_pair(3, -5);
            keep = bit_q.size();
            push_pair(-7, 100);
            keep = bit_q.size() - keep;
            drive_bits(100, keep);
            cyc = 0;
            while (!out_valid_o && cyc < 50) begin
                step(1'b0, 1'b0);
                cyc++;
            end
            check("bp_valid_seen", 32'(out_valid_o), 32'd1);
            for (int i = 0; i < 3; i++) begin
                step(1'($urandom_range(1)), bit_q[0]);
                check("bp_ready_low", 32'(bit_ready_o), 32'd0);
            end
            check("bp_bits_kept", 32'(bit_q.size()), 32'(keep));
            ready_mode = 1;
            drive_bits(70, 0);
            wait_drain(100);
        end

        // clr_i mid-SUFFIX of y, with a bit offered in the same cycle
        push_bits(42'b1_0001_0, 6);
        drive_bits(100, 0);
        step(1'b1, 1'b1);
        clr_i = 1'b1;
        step(1'b0, 1'b0);
        clr_i = 1'b0;
        check("clr_state", 32'(dbg_state), 32'(ST_IDLE));
        check("clr_no_valid", 32'(out_valid_o), 32'd0);
        push_bits(42'b010_1, 4);
        exp_q.push_back({11'd1, 11'd0, 6'd4});
        drive_bits(100, 0);
        wait_drain(50);

        // rstn mid-SUFFIX of y
        push_bits(42'b1_0001_0, 6);
        drive_bits(100, 0);
        step(1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bit_ready_o), 32'd0);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_len", 32'(len_o), 32'd0);
        step(1'b0, 1'b0);
        rstn = 1'b1;
        step(1'b0, 1'b0);
        check("mid_rst_ready_back", 32'(bit_ready_o), 32'd1);
        push_bits(42'b010_1, 4);
        exp_q.push_back({11'd1, 11'd0, 6'd4});
        drive_bits(100, 0);
        wait_drain(50);

        // random pairs against the value-level model
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int x, y;
            x = ($urandom_range(3) == 0) ? int'($urandom_range(2046)) - 1023
                                         : int'($urandom_range(20)) - 10;
            y = ($urandom_range(3) == 0) ? int'($urandom_range(2046)) - 1023
                                         : int'($urandom_range(20)) - 10;
            push_pair(x, y);
        end
        drive_bits(70, 0);
        wait_drain(500);
        ready_mode = 1;

        check("total_err_pulses", 32'(err_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
